// File: rtl/press_classifier_if.sv
// Button-classifier signal bundle: debounced inputs from the debouncer side and
// the registered gesture pulses back to the consumer.
interface press_classifier_if;
   logic btn_level;
   logic btn_event;
   logic short_press;
   logic long_press;
   logic double_press;
   logic held;

   modport master (
      output btn_level,
      output btn_event,
      input  short_press,
      input  long_press,
      input  double_press,
      input  held
   );

   modport slave (
      input  btn_level,
      input  btn_event,
      output short_press,
      output long_press,
      output double_press,
      output held
   );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double presses.
// One shared counter times either the hold (PRESSED) or the release gap (WAIT_SECOND).
module press_classifier #(
   parameter int unsigned LONG_CYCLES = 50_000_000,
   parameter int unsigned DBL_CYCLES  = 12_500_000,
   parameter int unsigned CNT_W       = 26
) (
   input logic               clk,
   input logic               rst,
   press_classifier_if.slave bus
);

   localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DblLast  = CNT_W'(DBL_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPressed,
      StLongHeld,
      StWaitSecond,
      StSecondHeld
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             double_q, double_d;
   logic             held_q, held_d;

   logic press, release_ev;
   assign press      = bus.btn_event & bus.btn_level;
   assign release_ev = bus.btn_event & ~bus.btn_level;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         double_q <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         long_q   <= long_d;
         double_q <= double_d;
         held_q   <= held_d;
      end
   end

   // Release beats the long timeout; press beats the double-press timeout.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (press) begin
               state_d = StPressed;
               cnt_d   = '0;
            end
         end
         StPressed: begin
            if (release_ev) begin
               state_d = StWaitSecond;
               cnt_d   = '0;
            end else if (cnt_q == LongLast) begin
               state_d = StLongHeld;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StLongHeld: begin
            if (release_ev) state_d = StIdle;
         end
         StWaitSecond: begin
            if (press) begin
               state_d = StSecondHeld;
               cnt_d   = '0;
            end else if (cnt_q == DblLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSecondHeld: begin
            if (release_ev) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      short_d  = (state_q == StWaitSecond) && !press && (cnt_q == DblLast);
      long_d   = (state_q == StPressed) && !release_ev && (cnt_q == LongLast);
      double_d = (state_q == StWaitSecond) && press;
      held_d   = bus.btn_level;
   end

   assign bus.short_press  = short_q;
   assign bus.long_press   = long_q;
   assign bus.double_press = double_q;
   assign bus.held         = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Scenario bench for press_classifier: expected output vectors are queued as each
// cycle's stimulus is driven and compared once the edge has produced the outputs.
module tb_press_classifier;

   localparam int unsigned LongCycles = 10;
   localparam int unsigned DblCycles  = 5;

   localparam int KShort = 0;
   localparam int KLong  = 1;
   localparam int KDbl   = 2;

   localparam int EvPress   = 1;
   localparam int EvRelease = 2;
   localparam int EvReset   = 3;
   localparam int EvLevelHi = 4;
   localparam int EvSpurPr  = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   press_classifier_if bus ();

   press_classifier #(
      .LONG_CYCLES(LongCycles),
      .DBL_CYCLES (DblCycles),
      .CNT_W      (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int cyc;
      int kind;
   } item_t;

   item_t      evs[$];
   item_t      exps[$];
   logic [3:0] sb[$];
   logic       lvl;
   int         checks = 0;
   int         errors = 0;

   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got {short,long,dbl,held}=%b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.short_press, bus.long_press, bus.double_press, bus.held};
   endfunction

   function automatic bit exp_at(input int cyc, input int kind);
      foreach (exps[i]) if (exps[i].cyc == cyc && exps[i].kind == kind) return 1'b1;
      return 1'b0;
   endfunction

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst           = 1'b1;
      bus.btn_event = 1'b0;
      bus.btn_level = 1'b0;
      lvl           = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check_eq({tag, "/reset"}, outs(), 4'b0000);
   endtask

   // Cycle n drives the inputs sampled by edge n; outputs seen after that edge are cycle n+1.
   task automatic run(input string tag, input int ncyc);
      logic       r;
      logic       ev;
      logic [3:0] exp;
      logic [3:0] got;
      do_reset(tag);
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         r  = 1'b0;
         ev = 1'b0;
         foreach (evs[i]) begin
            if (evs[i].cyc == n) begin
               case (evs[i].kind)
                  EvPress, EvSpurPr: begin lvl = 1'b1; ev = 1'b1; end
                  EvRelease:         begin lvl = 1'b0; ev = 1'b1; end
                  EvReset:           r = 1'b1;
                  EvLevelHi:         lvl = 1'b1;
                  default:           ;
               endcase
            end
         end
         rst           = r;
         bus.btn_event = ev;
         bus.btn_level = lvl;
         exp = {exp_at(n + 1, KShort), exp_at(n + 1, KLong), exp_at(n + 1, KDbl), lvl & ~r};
         sb.push_back(exp);
         @(posedge clk);
         #1;
         got = outs();
         check_eq($sformatf("%s/cyc%0d", tag, n + 1), got, sb.pop_front());
      end
   endtask

   task automatic ev(input int cyc, input int kind);
      item_t it;
      it.cyc  = cyc;
      it.kind = kind;
      evs.push_back(it);
   endtask

   task automatic ex(input int cyc, input int kind);
      item_t it;
      it.cyc  = cyc;
      it.kind = kind;
      exps.push_back(it);
   endtask

   task automatic clear();
      evs.delete();
      exps.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      bus.btn_event = 1'b0;
      bus.btn_level = 1'b0;
      lvl           = 1'b0;

      // Short press; a spurious press event while pressed is ignored.
      clear();
      ev(0, EvPress); ev(2, EvSpurPr); ev(3, EvRelease);
      ex(9, KShort);
      run("short", 16);

      // Long press, release afterwards produces nothing.
      clear();
      ev(0, EvPress); ev(20, EvRelease);
      ex(11, KLong);
      run("long", 28);

      // Release on the long-timeout cycle wins.
      clear();
      ev(0, EvPress); ev(10, EvRelease);
      ex(16, KShort);
      run("rel_at_long", 22);

      // Double press; long hold of the second press gives no long_press.
      clear();
      ev(0, EvPress); ev(3, EvRelease); ev(6, EvPress); ev(30, EvRelease);
      ex(7, KDbl);
      run("double", 38);

      // Second press on the double-press timeout cycle wins.
      clear();
      ev(0, EvPress); ev(3, EvRelease); ev(8, EvPress); ev(10, EvRelease);
      ex(9, KDbl);
      run("dbl_at_timeout", 18);

      // Reset mid-gesture discards it; a fresh press classifies normally.
      clear();
      ev(0, EvPress); ev(3, EvRelease); ev(5, EvReset); ev(21, EvPress); ev(22, EvRelease);
      ex(28, KShort);
      run("reset_mid", 32);

      // Button already held across reset: no classification until a new press.
      clear();
      ev(0, EvLevelHi); ev(0, EvReset); ev(15, EvRelease); ev(16, EvPress); ev(17, EvRelease);
      ex(23, KShort);
      run("held_thru_reset", 28);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
